serial_comp_ctrl: RTL
=====================

SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; it SHALL be even and at least 2.
REQ-002 The block SHALL have derived constant NDIG = WIDTH/2, the number of 2-bit digits scanned.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port start  input  1  request a comparison; sampled only in IDLE.
REQ-007 Port a  input  WIDTH  operand A, captured on the accepted start.
REQ-008 Port b  input  WIDTH  operand B, captured on the accepted start.
REQ-009 Port slice_a  output  2  current digit of the captured A, to the external 2-bit comparator.
REQ-010 Port slice_b  output  2  current digit of the captured B, to the external 2-bit comparator.
REQ-011 Port slice_eq  input  1  comparator result, slice_a == slice_b.
REQ-012 Port slice_gt  input  1  comparator result, slice_a > slice_b.
REQ-013 Port slice_lt  input  1  comparator result, slice_a < slice_b.
REQ-014 Port busy  output  1  high in SCAN.
REQ-015 Port done  output  1  one-cycle pulse when a result is valid.
REQ-016 Port a_eq_b  output  1  registered result, A == B.
REQ-017 Port a_gt_b  output  1  registered result, A > B, unsigned.
REQ-018 Port a_lt_b  output  1  registered result, A < B, unsigned.
REQ-019 Port err  output  1  registered flag: the slice flags were not one-hot during the scan.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-021 In IDLE with start=1, the block SHALL capture a and b, set digit index to NDIG-1, clear a_eq_b, a_gt_b, a_lt_b and err, and go to SCAN.
REQ-022 In IDLE with start=0, the block SHALL stay in IDLE with all outputs held.
REQ-023 slice_a and slice_b SHALL be driven combinationally from the captured operands at the digit index: bits [2*idx+1 : 2*idx], MSB digit first.
REQ-024 Outside SCAN, slice_a and slice_b SHALL be 2'b00.
REQ-025 In SCAN, the block SHALL sample the slice flags once per cycle.
REQ-026 In SCAN, if slice_gt=1 and the slice flags are one-hot, the block SHALL set a_gt_b and go to DONE.
REQ-027 In SCAN, if slice_lt=1 and the slice flags are one-hot, the block SHALL set a_lt_b and go to DONE.
REQ-028 In SCAN, if slice_eq=1 and idx=0, the block SHALL set a_eq_b and go to DONE.
REQ-029 In SCAN, if slice_eq=1 and idx>0, the block SHALL decrement idx and stay in SCAN.
REQ-030 In SCAN, if the slice flags are not one-hot (zero or more than one set), the block SHALL set err, leave all three result outputs at 0, and go to DONE immediately.
REQ-031 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-032 Latency: with the deciding digit at scan step k (1..NDIG), done SHALL be high in the (k+1)-th cycle after the start edge.
REQ-033 Worst-case latency SHALL be NDIG+1 cycles.
REQ-034 Result outputs and err SHALL hold their values after DONE until the next accepted start.
REQ-035 At most one of a_eq_b, a_gt_b and a_lt_b SHALL ever be high.
REQ-036 start SHALL be ignored in SCAN and DONE; operands SHALL not be recaptured.
REQ-037 Changes on a and b after capture SHALL not affect the result.
REQ-038 Start in the IDLE cycle directly after DONE SHALL be accepted, giving back-to-back operation.
REQ-039 busy SHALL be 1 exactly in SCAN; done SHALL be 1 exactly in DONE.

Reset
REQ-040 While rst=1, asynchronously: state SHALL be IDLE, idx SHALL be 0, captured operands SHALL be 0, and busy, done, a_eq_b, a_gt_b, a_lt_b and err SHALL be 0.
REQ-041 Reset asserted mid-SCAN SHALL abort the scan with no done pulse and no partial result.
REQ-042 After rst deasserts, the first rising edge SHALL be able to accept start.

Verification
The bench uses WIDTH=8 and a behavioural 2-bit comparator on the slice ports.
REQ-043 a=8'hA5, b=8'hA5, start pulse -> busy for 4 cycles, done in cycle 5, a_eq_b=1, err=0.
REQ-044 a=8'hC0, b=8'h3F -> done in cycle 2, a_gt_b=1; slice_a=2'b11 and slice_b=2'b00 in the single SCAN cycle.
REQ-045 a=8'h12, b=8'h13 -> 4 SCAN cycles, then a_lt_b=1; the digit sequence is (00,00),(01,01),(00,00),(10,11).
REQ-046 start held high with new operands throughout a scan -> first operands compared; a second start is accepted only in IDLE after DONE, back-to-back.
REQ-047 rst pulsed in the 2nd SCAN cycle -> all outputs 0 immediately, no done; a following start runs normally.
REQ-048 Slice model forced to drive eq=1 and gt=1 -> err=1, results 0, done pulse asserted.

Source files
------------

// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl: compares two unsigned operands one 2-bit digit at a time,
// MSB digit first, using an external 2-bit comparator on the slice ports.
// Stops at the first unequal digit. Flags a non-one-hot comparator response
// as an error.
module serial_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic             slice_eq,
    input  logic             slice_gt,
    input  logic             slice_lt,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             err
);

    localparam int NDIG  = WIDTH / 2;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_cap_q, a_cap_d;
    logic [WIDTH-1:0] b_cap_q, b_cap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             err_q, err_d;

    logic [1:0]       dig_a, dig_b;
    logic             flags_onehot;

    // Select the current digit of each captured operand; idle slices read as zero.
    always_comb begin
        dig_a = 2'b00;
        dig_b = 2'b00;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_a = a_cap_q[2*i +: 2];
                dig_b = b_cap_q[2*i +: 2];
            end
        end
        slice_a = (state_q == SCAN) ? dig_a : 2'b00;
        slice_b = (state_q == SCAN) ? dig_b : 2'b00;
    end

    // Exactly one comparator flag must be set for the response to be trusted.
    always_comb begin
        flags_onehot = ({slice_eq, slice_gt, slice_lt} == 3'b100) ||
                       ({slice_eq, slice_gt, slice_lt} == 3'b010) ||
                       ({slice_eq, slice_gt, slice_lt} == 3'b001);
    end

    // Next-state and registered-output logic for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_cap_d = a_cap_q;
        b_cap_d = b_cap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_cap_d = a;
                    b_cap_d = b;
                    idx_d   = IDX_TOP;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!flags_onehot) begin
                    // Untrusted comparator response: report error, no result.
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (slice_gt) begin
                    gt_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (slice_lt) begin
                    lt_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    // Last digit equal: every digit matched.
                    eq_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous reset that aborts any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_cap_q <= '0;
            b_cap_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_cap_q <= a_cap_d;
            b_cap_q <= b_cap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_eq_b = eq_q;
    assign a_gt_b = gt_q;
    assign a_lt_b = lt_q;
    assign err    = err_q;

endmodule
